// File: rtl/slice_nibble_tx.sv
// ---------------------------------------------------------------------------
// slice_nibble_tx
//   Return-path transmitter for the XMOS slice CPLD. Bytes arrive from
//   internal CPLD logic on a valid/ready interface and are queued in a small
//   FIFO. Each byte goes to the tile as two nibbles (low first) on the slice
//   pins, each nibble framed by a 4-phase STB/ACK handshake. A per-edge
//   timeout guards against a silent or stuck tile.
//
// Ports
//   CLK, RST      clock, synchronous active-high reset
//   TX_DATA       byte to send
//   TX_VALID      TX_DATA valid
//   TX_READY      FIFO can accept (transfer on TX_VALID & TX_READY)
//   P_D, P_HI     nibble and nibble select (0 = low, 1 = high) to the pins
//   P_STB         strobe to tile
//   P_ACK         acknowledge from tile (asynchronous)
//   ERR, ERR_CLR  sticky timeout flag and its clear
//   FIFO_LEVEL    bytes held in the FIFO, excluding the byte in flight
//   BUSY          handshake engine not idle
// ---------------------------------------------------------------------------
module slice_nibble_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int TIMEOUT    = 1023
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [7:0]                  TX_DATA,
  input  logic                        TX_VALID,
  output logic                        TX_READY,
  output logic [3:0]                  P_D,
  output logic                        P_HI,
  output logic                        P_STB,
  input  logic                        P_ACK,
  output logic                        ERR,
  input  logic                        ERR_CLR,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                        BUSY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0]   SETUP_LAST   = 16'(SETUP_CYC - 1);
  localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [LW-1:0] LEVEL_FULL   = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_DRAIN
  } state_t;

  // -------------------------------------------------------------------------
  // Byte FIFO
  // -------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic          ready_en_reg;
  logic          push;
  logic          pop;
  logic [7:0]    head_byte;

  // ready_en_reg holds TX_READY low for the cycles reset is applied and
  // releases it on the first edge with RST low.
  assign TX_READY  = ready_en_reg && (level_reg < LEVEL_FULL);
  assign push      = TX_VALID && TX_READY;
  assign head_byte = fifo_mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= TX_DATA;
    end
  end

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      level_reg    <= level_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // ACK synchronizer: every handshake decision uses ack_s_reg only.
  // -------------------------------------------------------------------------
  logic ack_meta_reg;
  logic ack_s_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ack_meta_reg <= 1'b0;
      ack_s_reg    <= 1'b0;
    end else begin
      ack_meta_reg <= P_ACK;
      ack_s_reg    <= ack_meta_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Handshake FSM
  // -------------------------------------------------------------------------
  state_t      state_reg,  state_next;
  logic [15:0] cnt_reg,    cnt_next;
  logic [3:0]  hi_nib_reg, hi_nib_next;
  logic [3:0]  pd_reg,     pd_next;
  logic        phi_reg,    phi_next;
  logic        stb_reg,    stb_next;
  logic        err_reg,    err_next;
  logic        timeout_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      hi_nib_reg <= '0;
      pd_reg     <= '0;
      phi_reg    <= 1'b0;
      stb_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hi_nib_reg <= hi_nib_next;
      pd_reg     <= pd_next;
      phi_reg    <= phi_next;
      stb_reg    <= stb_next;
      err_reg    <= err_next;
    end
  end

  // cnt_reg is cleared on every state entry, so in STROBE/RELEASE it counts
  // waiting cycles; the abort fires on the edge that would make it TIMEOUT.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + 16'd1;
    hi_nib_next = hi_nib_reg;
    pd_next     = pd_reg;
    phi_next    = phi_reg;
    stb_next    = stb_reg;
    timeout_hit = 1'b0;
    pop         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (level_reg != '0) begin
          pop         = 1'b1;
          hi_nib_next = head_byte[7:4];
          pd_next     = head_byte[3:0];
          phi_next    = 1'b0;
          state_next  = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          stb_next   = 1'b1;
          cnt_next   = '0;
          state_next = S_STROBE;
        end
      end

      S_STROBE: begin
        if (ack_s_reg) begin
          stb_next   = 1'b0;
          cnt_next   = '0;
          state_next = S_RELEASE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          stb_next    = 1'b0;
          timeout_hit = 1'b1;
          cnt_next    = '0;
          state_next  = S_DRAIN;
        end
      end

      S_RELEASE: begin
        if (!ack_s_reg) begin
          cnt_next = '0;
          if (!phi_reg) begin
            pd_next    = hi_nib_reg;
            phi_next   = 1'b1;
            state_next = S_SETUP;
          end else begin
            phi_next   = 1'b0;
            state_next = S_IDLE;
          end
        end else if (cnt_reg == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          cnt_next    = '0;
          state_next  = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // No timeout here: the byte is already abandoned, just wait for the
        // tile to release ACK so the next byte starts from a clean handshake.
        cnt_next = '0;
        if (!ack_s_reg) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase

    // A timeout in the same cycle as ERR_CLR must not be lost.
    if (timeout_hit) begin
      err_next = 1'b1;
    end else if (ERR_CLR) begin
      err_next = 1'b0;
    end else begin
      err_next = err_reg;
    end
  end

  assign P_D        = pd_reg;
  assign P_HI       = phi_reg;
  assign P_STB      = stb_reg;
  assign ERR        = err_reg;
  assign FIFO_LEVEL = level_reg;
  assign BUSY       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_slice_nibble_tx.sv
// ---------------------------------------------------------------------------
// tb_slice_nibble_tx
//   Bench for slice_nibble_tx (FIFO_DEPTH=4, SETUP_CYC=1, TIMEOUT=8).
//   A tile model drives P_ACK; a monitor captures the nibble at every STB
//   rise and compares it with a queue of expected {P_HI, P_D} values that
//   the bench builds from each accepted byte.
// ---------------------------------------------------------------------------
module tb_slice_nibble_tx;

  localparam int DEPTH = 4;
  localparam int SETUP = 1;
  localparam int TMO   = 8;

  localparam int T_NORMAL = 0;
  localparam int T_SILENT = 1;
  localparam int T_STUCK  = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic [3:0] P_D;
  logic       P_HI;
  logic       P_STB;
  logic       P_ACK;
  logic       ERR;
  logic       ERR_CLR;
  logic [2:0] FIFO_LEVEL;
  logic       BUSY;

  int checks    = 0;
  int errors    = 0;
  int stb_rises = 0;
  int tile_mode = T_NORMAL;
  int tile_dly  = 1;
  logic [4:0] exp_nibs [$];

  always #5 CLK = ~CLK;

  slice_nibble_tx #(
    .FIFO_DEPTH (DEPTH),
    .SETUP_CYC  (SETUP),
    .TIMEOUT    (TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY),
    .P_D        (P_D),
    .P_HI       (P_HI),
    .P_STB      (P_STB),
    .P_ACK      (P_ACK),
    .ERR        (ERR),
    .ERR_CLR    (ERR_CLR),
    .FIFO_LEVEL (FIFO_LEVEL),
    .BUSY       (BUSY)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic push_byte(input logic [7:0] b, input bit low_only);
    int n = 0;
    TX_DATA  = b;
    TX_VALID = 1'b1;
    while (TX_READY !== 1'b1 && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 500) check_eq("push_ready_wait", TX_READY, 1);
    @(posedge CLK);
    exp_nibs.push_back({1'b0, b[3:0]});
    if (!low_only) exp_nibs.push_back({1'b1, b[7:4]});
    $display("push byte 0x%02h%s", b, low_only ? " (expect low nibble only)" : "");
    #1;
    TX_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while ((BUSY !== 1'b0 || FIFO_LEVEL !== 3'd0) && n < 2000);
    check_eq("idle_reached", {BUSY, FIFO_LEVEL}, 0);
  endtask

  // Tile: in normal mode ACK follows STB delayed by tile_dly cycles.
  initial begin
    logic [3:0] hist;
    hist  = '0;
    P_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      case (tile_mode)
        T_NORMAL: P_ACK = (tile_dly == 0) ? (P_STB === 1'b1) : hist[tile_dly-1];
        T_SILENT: P_ACK = 1'b0;
        default:  P_ACK = 1'b1;
      endcase
      hist = {hist[2:0], P_STB === 1'b1};
    end
  end

  // Nibble monitor: one expected nibble per STB pulse, held through the pulse.
  initial begin
    logic       stb_prev;
    logic [4:0] cap;
    logic [4:0] e_nib;
    stb_prev = 1'b0;
    cap      = '0;
    forever begin
      @(negedge CLK);
      if (P_STB === 1'b1 && !stb_prev) begin
        stb_rises++;
        cap = {P_HI, P_D};
        if (exp_nibs.size() == 0) begin
          check_eq("nibble_unexpected", exp_nibs.size(), 1);
        end else begin
          e_nib = exp_nibs.pop_front();
          check_eq("nibble", cap, e_nib);
        end
      end else if (P_STB === 1'b0 && stb_prev && RST === 1'b0) begin
        check_eq("nibble_hold", {P_HI, P_D}, cap);
      end
      stb_prev = (P_STB === 1'b1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [4:0] nib0;
    int         n;
    bit         changed;

    RST = 1'b1; TX_DATA = '0; TX_VALID = 1'b0; ERR_CLR = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_outputs", {P_D, P_HI, P_STB, ERR, BUSY}, 0);
    check_eq("rst_ready", TX_READY, 0);
    check_eq("rst_level", FIFO_LEVEL, 0);
    RST = 1'b0;
    @(posedge CLK); #1;
    check_eq("ready_after_rst", TX_READY, 1);

    // ---- single byte ----
    tile_mode = T_NORMAL; tile_dly = 1;
    stb_rises = 0;
    push_byte(8'hA5, 1'b0);
    wait_idle();
    check_eq("single_pulses", stb_rises, 2);
    check_eq("single_err", ERR, 0);
    check_eq("single_queue", exp_nibs.size(), 0);

    // ---- FIFO full / back-to-back with a slow tile ----
    tile_dly = 3;
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b0);
    check_eq("full_level", FIFO_LEVEL, 4);
    check_eq("full_ready", TX_READY, 0);
    TX_DATA = 8'h66; TX_VALID = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    TX_VALID = 1'b0;
    check_eq("full_push_ignored", FIFO_LEVEL, 4);
    wait_idle();
    check_eq("full_queue", exp_nibs.size(), 0);

    // ---- strobe timeout with exact timing ----
    tile_mode = T_SILENT;
    push_byte(8'h3C, 1'b1);
    @(posedge CLK); #1;
    check_eq("lat_pd", {P_HI, P_D}, 5'h0C);
    check_eq("lat_stb_low", {P_STB, BUSY}, 2'b01);
    @(posedge CLK); #1;
    check_eq("lat_stb_high", P_STB, 1);
    repeat (7) begin @(posedge CLK); #1; end
    check_eq("tmo_before", {P_STB, ERR}, 2'b10);
    @(posedge CLK); #1;
    check_eq("tmo_after", {P_STB, ERR}, 2'b01);
    tile_mode = T_NORMAL; tile_dly = 1;
    wait_idle();
    push_byte(8'h7E, 1'b0);
    wait_idle();
    check_eq("tmo_queue", exp_nibs.size(), 0);
    check_eq("err_sticky", ERR, 1);
    ERR_CLR = 1'b1;
    @(posedge CLK); #1;
    ERR_CLR = 1'b0;
    check_eq("err_clr", ERR, 0);

    // ---- ERR_CLR on the timeout cycle ----
    tile_mode = T_SILENT;
    push_byte(8'hD2, 1'b1);
    repeat (9) begin @(posedge CLK); #1; end
    check_eq("coll_pre", ERR, 0);
    ERR_CLR = 1'b1;
    @(posedge CLK); #1;
    ERR_CLR = 1'b0;
    check_eq("coll_set_wins", ERR, 1);
    ERR_CLR = 1'b1;
    @(posedge CLK); #1;
    ERR_CLR = 1'b0;
    check_eq("coll_clr_later", ERR, 0);
    tile_mode = T_NORMAL; tile_dly = 0;
    wait_idle();

    // ---- ACK stuck high after the low nibble ----
    b = 8'h94;
    push_byte(b, 1'b1);
    n = 0;
    while (P_ACK !== 1'b1 && n < 50) begin @(posedge CLK); #1; n++; end
    check_eq("stuck_ack_seen", P_ACK, 1);
    tile_mode = T_STUCK;
    nib0 = {1'b0, b[3:0]};
    changed = 1'b0;
    repeat (20) begin
      @(posedge CLK); #1;
      if ({P_HI, P_D} !== nib0) changed = 1'b1;
    end
    check_eq("stuck_err", ERR, 1);
    check_eq("stuck_drain_busy", {BUSY, P_STB}, 2'b10);
    check_eq("stuck_pd_stable", changed, 0);
    tile_mode = T_NORMAL;
    n = 0;
    while (BUSY !== 1'b0 && n < 5) begin @(posedge CLK); #1; n++; end
    check_eq("stuck_release_idle", BUSY, 0);
    check_eq("stuck_queue", exp_nibs.size(), 0);
    ERR_CLR = 1'b1;
    @(posedge CLK); #1;
    ERR_CLR = 1'b0;

    // ---- randomized traffic ----
    for (int batch = 0; batch < 4; batch++) begin
      tile_dly = $urandom_range(0, 3);
      for (int i = 0; i < 10; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
        push_byte(8'($urandom_range(0, 255)), 1'b0);
      end
      wait_idle();
      check_eq("rand_err", ERR, 0);
      check_eq("rand_queue", exp_nibs.size(), 0);
    end

    // ---- reset during the high-nibble strobe ----
    tile_dly = 3;
    for (int i = 0; i < 4; i++) push_byte(8'h50 + 8'(i), 1'b0);
    n = 0;
    while (!(P_STB === 1'b1 && P_HI === 1'b1) && n < 200) begin @(posedge CLK); #1; n++; end
    check_eq("mid_hi_strobe", {P_STB, P_HI}, 2'b11);
    check_eq("mid_level", FIFO_LEVEL, 3);
    RST = 1'b1;
    @(posedge CLK); #1;
    check_eq("mid_rst_stb_busy", {P_STB, BUSY}, 0);
    check_eq("mid_rst_level", FIFO_LEVEL, 0);
    check_eq("mid_rst_pins", {P_HI, P_D}, 0);
    @(posedge CLK); #1;
    check_eq("mid_rst_ready", TX_READY, 0);
    RST = 1'b0;
    exp_nibs.delete();
    @(posedge CLK); #1;
    check_eq("mid_ready_after", TX_READY, 1);
    repeat (10) begin @(posedge CLK); #1; end
    check_eq("mid_quiet", {BUSY, P_STB}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
